cv32e40x_register_file_sb: RTL and testbench
============================================

# cv32e40x_register_file_sb

Parametrised integer register file with a per-register pending-write scoreboard and a sequential clear engine. It is the next-generation register file for the cv32e40x core: generic in read/write port count, depth (RV32I/RV32E) and word width (parity/ECC bits). It tracks registers with outstanding writebacks, such as loads and multi-cycle ops, so the ID stage can stall on hazards. It sits between the ID stage (read and issue) and the WB stage (write ports).

## Interface
Parameters:
- NUM_READ_PORTS, 2, number of combinational read ports (1..4)
- NUM_WRITE_PORTS, 2, number of write ports (1..3); the highest index has priority
- NUM_WORDS, 32, implemented registers; legal values 32 (RV32I) or 16 (RV32E)
- WORD_WIDTH, 32, stored word width (≥32; extra bits carry parity/ECC)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- raddr_i  in  NUM_READ_PORTS×5  read addresses
- rdata_o  out  NUM_READ_PORTS×WORD_WIDTH  read data
- rbusy_o  out  NUM_READ_PORTS  addressed register has a pending write
- waddr_i  in  NUM_WRITE_PORTS×5  write addresses
- wdata_i  in  NUM_WRITE_PORTS×WORD_WIDTH  write data
- we_i  in  NUM_WRITE_PORTS  write enables
- issue_valid_i  in  1  an instruction with a deferred writeback issues to issue_addr_i
- issue_addr_i  in  5  destination register of the issuing instruction
- issue_ready_o  out  1  issue accepted this cycle
- clear_req_i  in  1  request a full register-file clear
- clear_busy_o  out  1  clear engine active

## Operation
- Storage: mem[NUM_WORDS] and busy[NUM_WORDS].
  - mem[0] always reads 0 and busy[0] is always 0.
  - Addresses ≥ NUM_WORDS (bit 4 set when NUM_WORDS=16) are out of range: writes and issues to them are dropped, and reads return 0 with rbusy_o=0.
- Write: for each register r ≥ 1, if any port j has we_i[j] && waddr_i[j]==r, then mem[r] takes wdata_i of the highest such j.
  - Any such write also clears busy[r].
- Issue: the handshake is issue_valid_i && issue_ready_o. It sets busy[issue_addr_i], except for address 0 or out-of-range addresses.
  - issue_ready_o = !busy[issue_addr_i] && state==IDLE.
  - A same-cycle issue and write to the same register leaves busy=1 (issue wins).
- Clear FSM:
  - States: IDLE, CLEAR.
  - IDLE→CLEAR on clear_req_i. An 8-bit... no: a 5-bit index ptr loads 1.
  - In CLEAR, each cycle sets mem[ptr]=0 and busy[ptr]=0, then ptr++.
  - CLEAR→IDLE in the cycle ptr==NUM_WORDS-1 is cleared.
  - In CLEAR, all writes and issues are ignored; issue_ready_o=0 and clear_busy_o=1.
  - clear_req_i is ignored while in CLEAR.

## Timing
- Reset values: every mem word 0, busy all 0, state IDLE, ptr 1, clear_busy_o=0, issue_ready_o=1.
- rbusy_o and rdata_o follow the reset state (all zero).
- Reset asserted mid-clear aborts the clear and returns to IDLE immediately.
- Reads are combinational from registered state.
  - Write latency: the written value is visible on rdata_o the cycle after we_i.
  - Issue latency: busy is visible on rbusy_o and issue_ready_o the cycle after the issue handshake.
- A clear takes exactly NUM_WORDS-1 cycles in CLEAR: 31 for RV32I, 15 for RV32E.
  - clear_busy_o goes high the cycle after clear_req_i.

## Configuration
- Macro: CV32E40X_RF_BYPASS_EN.
- When defined, the same-cycle write bypass is enabled.
  - For each read port, if any write port writes raddr_i this cycle, rdata_o returns that port's wdata_i (highest index wins) and rbusy_o=0.
  - Address 0 is never bypassed. Writes are not bypassed during CLEAR.
- When undefined, reads return only stored state, and rbusy_o reflects the registered busy bit. Write-to-read latency is then 1 cycle.

## Test plan
- Reset, then read all 32 addresses on both ports → rdata_o=0, rbusy_o=0, issue_ready_o=1, clear_busy_o=0.
- Same cycle: we_i={1,1}, waddr_i={5,5}, wdata_i={0xAAAA_0000, 0x5555_1111} → next cycle, read x5 returns 0x5555_1111. Write x0=0xFFFF_FFFF → x0 still reads 0.
- Issue x7, then re-issue x7 the next cycle → issue_ready_o=0 and rbusy_o=1 on x7. Write x7=0x1234 → busy clears, and the following cycle issue_ready_o=1. With the bypass enabled, rdata_o=0x1234 and rbusy_o=0 already in the write cycle.
- Same-cycle issue and write to x9 → busy[9]=1 in the next cycle.
- With registers filled, pulse clear_req_i → clear_busy_o=1 for 31 cycles, with write attempts dropped. Afterwards all reads are 0, all busy bits are 0, and issue_ready_o=1. Assert rst at cycle 10 of the clear → IDLE with all registers 0.
- NUM_WORDS=16: write address 20=0xDEAD → dropped; read address 20 returns 0; issue to 20 leaves all busy bits 0.

Source files
------------

// File: rtl/cv32e40x_register_file_sb.sv
// Register file with per-register pending-write scoreboard and a sequential clear engine.
// Optional same-cycle write-to-read bypass: define CV32E40X_RF_BYPASS_EN.

module cv32e40x_register_file_sb_rport #(
  parameter int NUM_WORDS  = 32,
  parameter int WORD_WIDTH = 32
) (
  input  logic [4:0]                            raddr,
  input  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]  mem,
  input  logic [NUM_WORDS-1:0]                  busy,
  input  logic [NUM_WORDS-1:0]                  byp_en,
  input  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]  byp_data,
  output logic [WORD_WIDTH-1:0]                 rdata,
  output logic                                  rbusy
);
  // Full decode: addresses beyond NUM_WORDS match nothing and read as zero / not busy.
  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    for (int r = 0; r < NUM_WORDS; r++) begin
      if (raddr == 5'(r)) begin
        if (byp_en[r]) begin
          rdata = byp_data[r];
          rbusy = 1'b0;
        end else begin
          rdata = mem[r];
          rbusy = busy[r];
        end
      end
    end
  end
endmodule

module cv32e40x_register_file_sb #(
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int NUM_WORDS       = 32,
  parameter int WORD_WIDTH      = 32
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_READ_PORTS-1:0][4:0]                 raddr_i,
  output logic [NUM_READ_PORTS-1:0][WORD_WIDTH-1:0]      rdata_o,
  output logic [NUM_READ_PORTS-1:0]                      rbusy_o,
  input  logic [NUM_WRITE_PORTS-1:0][4:0]                waddr_i,
  input  logic [NUM_WRITE_PORTS-1:0][WORD_WIDTH-1:0]     wdata_i,
  input  logic [NUM_WRITE_PORTS-1:0]                     we_i,
  input  logic                                           issue_valid_i,
  input  logic [4:0]                                     issue_addr_i,
  output logic                                           issue_ready_o,
  input  logic                                           clear_req_i,
  output logic                                           clear_busy_o
);
  typedef enum logic {IDLE, CLEAR} state_e;

  localparam logic [4:0] LAST = 5'(NUM_WORDS - 1);

  state_e                                state;
  logic [4:0]                            ptr;
  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]  mem;
  logic [NUM_WORDS-1:0]                  busy;
  logic [NUM_WORDS-1:0]                  wr_en;
  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]  wr_data;
  logic [NUM_WORDS-1:0]                  byp_en;
  logic                                  issue_busy;
  logic                                  issue_fire;

  // Per-register write decode; later ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    for (int r = 1; r < NUM_WORDS; r++) begin
      for (int j = 0; j < NUM_WRITE_PORTS; j++) begin
        if (we_i[j] && waddr_i[j] == 5'(r)) begin
          wr_en[r]   = 1'b1;
          wr_data[r] = wdata_i[j];
        end
      end
    end
  end

  always_comb begin
    issue_busy = 1'b0;
    for (int r = 0; r < NUM_WORDS; r++)
      if (issue_addr_i == 5'(r)) issue_busy = busy[r];
  end

  assign issue_ready_o = !issue_busy && (state == IDLE);
  assign issue_fire    = issue_valid_i && issue_ready_o;
  assign clear_busy_o  = (state == CLEAR);

`ifdef CV32E40X_RF_BYPASS_EN
  assign byp_en = (state == IDLE) ? wr_en : '0;
`else
  assign byp_en = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 5'd1;
      mem   <= '0;
      busy  <= '0;
    end else if (state == CLEAR) begin
      for (int r = 1; r < NUM_WORDS; r++) begin
        if (ptr == 5'(r)) begin
          mem[r]  <= '0;
          busy[r] <= 1'b0;
        end
      end
      ptr <= ptr + 5'd1;
      if (ptr == LAST) begin
        state <= IDLE;
        ptr   <= 5'd1;
      end
    end else begin
      for (int r = 1; r < NUM_WORDS; r++) begin
        if (wr_en[r]) begin
          mem[r]  <= wr_data[r];
          busy[r] <= 1'b0;
        end
        // Issue after write: a same-cycle issue keeps the register pending.
        if (issue_fire && issue_addr_i == 5'(r)) busy[r] <= 1'b1;
      end
      if (clear_req_i) begin
        state <= CLEAR;
        ptr   <= 5'd1;
      end
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rport
    cv32e40x_register_file_sb_rport #(
      .NUM_WORDS  (NUM_WORDS),
      .WORD_WIDTH (WORD_WIDTH)
    ) u_rport (
      .raddr    (raddr_i[p]),
      .mem      (mem),
      .busy     (busy),
      .byp_en   (byp_en),
      .byp_data (wr_data),
      .rdata    (rdata_o[p]),
      .rbusy    (rbusy_o[p])
    );
  end
endmodule

// File: tb/tb_cv32e40x_register_file_sb.sv
module tb_cv32e40x_register_file_sb;
`ifdef CV32E40X_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][4:0]  raddr, waddr, raddr16, waddr16;
  logic [1:0][31:0] rdata, wdata, rdata16, wdata16;
  logic [1:0]       rbusy, we, rbusy16, we16;
  logic             iv, irdy, creq, cbusy, iv16, irdy16, creq16, cbusy16;
  logic [4:0]       ia, ia16;

  cv32e40x_register_file_sb dut (
    .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .issue_valid_i(iv), .issue_addr_i(ia),
    .issue_ready_o(irdy), .clear_req_i(creq), .clear_busy_o(cbusy));

  cv32e40x_register_file_sb #(.NUM_WORDS(16)) dut16 (
    .clk(clk), .rst(rst), .raddr_i(raddr16), .rdata_o(rdata16), .rbusy_o(rbusy16),
    .waddr_i(waddr16), .wdata_i(wdata16), .we_i(we16), .issue_valid_i(iv16), .issue_addr_i(ia16),
    .issue_ready_o(irdy16), .clear_req_i(creq16), .clear_busy_o(cbusy16));

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] val;
    string       name;
  } ent_t;

  ent_t        q[$];
  ent_t        e;
  logic [31:0] act;
  int          total = 0;
  int          bad = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        0: act = rdata[e.idx];
        1: act = 32'(rbusy[e.idx]);
        2: act = 32'(irdy);
        3: act = 32'(cbusy);
        4: act = rdata16[e.idx];
        5: act = 32'(rbusy16[e.idx]);
        6: act = 32'(irdy16);
        default: act = 32'(cbusy16);
      endcase
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.val, $time);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: test did not complete, total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic chk(input int k, input int i, input logic [31:0] v, input string n);
    ent_t x;
    x.kind = k; x.idx = i; x.val = v; x.name = n;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; iv = 1'b0; creq = 1'b0;
    we16 = '0; iv16 = 1'b0; creq16 = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    we[p] = 1'b1; waddr[p] = a; wdata[p] = d;
  endtask

  task automatic wr16(input int p, input logic [4:0] a, input logic [31:0] d);
    we16[p] = 1'b1; waddr16[p] = a; wdata16[p] = d;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    raddr = '0; waddr = '0; wdata = '0; ia = '0;
    raddr16 = '0; waddr16 = '0; wdata16 = '0; ia16 = '0;
    tick();
    total++;
    if (irdy !== 1'b1 || cbusy !== 1'b0 || rbusy !== 2'b00 || rdata !== '0 ||
        irdy16 !== 1'b1 || cbusy16 !== 1'b0 || rbusy16 !== 2'b00 || rdata16 !== '0) begin
      bad++;
      $display("FAIL rst_state: irdy=%b cbusy=%b rbusy=%b rdata=%h irdy16=%b cbusy16=%b at %0t",
               irdy, cbusy, rbusy, rdata, irdy16, cbusy16, $time);
    end
    raddr[1] = 5'd7;
    chk(2, 0, 1, "rst_irdy"); chk(3, 0, 0, "rst_cbusy"); chk(0, 1, 0, "rst_rd");
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr[0] = 5'(a); raddr[1] = 5'(31 - a);
      chk(0, 0, 0, "rst_rd0"); chk(0, 1, 0, "rst_rd1");
      chk(1, 0, 0, "rst_busy0"); chk(1, 1, 0, "rst_busy1");
      tick();
    end

    idle(); wr(0, 5, 32'hAAAA_0000); wr(1, 5, 32'h5555_1111); raddr[0] = 5;
    chk(0, 0, BYP ? 32'h5555_1111 : 32'h0, "wr_same_cyc");
    tick();
    idle(); wr(0, 0, 32'hFFFF_FFFF); wr(1, 3, 32'h33); raddr[0] = 5; raddr[1] = 0;
    chk(0, 0, 32'h5555_1111, "wr_prio"); chk(0, 1, 0, "x0_wcyc");
    tick();
    idle(); raddr[0] = 0; raddr[1] = 3;
    chk(0, 0, 0, "x0_zero"); chk(0, 1, 32'h33, "wr_p1");
    tick();

    idle(); iv = 1; ia = 7; raddr[0] = 7;
    chk(2, 0, 1, "iss_rdy"); chk(1, 0, 0, "iss_busy_pre");
    tick();
    iv = 1; ia = 7;
    chk(2, 0, 0, "reiss_rdy"); chk(1, 0, 1, "iss_busy");
    tick();
    idle(); ia = 7; wr(0, 7, 32'h1234);
    chk(0, 0, BYP ? 32'h1234 : 32'h0, "byp_data"); chk(1, 0, BYP ? 32'h0 : 32'h1, "byp_busy");
    chk(2, 0, 0, "rdy_wcyc");
    tick();
    idle();
    chk(0, 0, 32'h1234, "wr7"); chk(1, 0, 0, "busy7_clr"); chk(2, 0, 1, "rdy7");
    tick();

    idle(); iv = 1; ia = 9; wr(1, 9, 32'h99);
    tick();
    idle(); raddr[1] = 9;
    chk(1, 1, 1, "iss_wins"); chk(0, 1, 32'h99, "iss_wr_data"); chk(2, 0, 0, "rdy9");
    tick();

    for (int r = 1; r < 32; r++) begin
      idle(); wr(0, 5'(r), 32'h100 + 32'(r));
      tick();
    end
    idle(); iv = 1; ia = 12;
    tick();
    idle(); raddr[0] = 12; raddr[1] = 31; creq = 1;
    chk(1, 0, 1, "fill_busy"); chk(0, 1, 32'h11F, "fill31"); chk(3, 0, 0, "cbusy_req");
    tick();
    for (int k = 1; k <= 31; k++) begin
      idle(); wr(0, 2, 32'hBAD); iv = 1; ia = 3; raddr[0] = 2; raddr[1] = 31;
      chk(3, 0, 1, "clr_cbusy"); chk(2, 0, 0, "clr_irdy");
      chk(0, 0, (k <= 2) ? 32'h102 : 32'h0, "clr_drop_wr"); chk(0, 1, 32'h11F, "clr_x31");
      tick();
    end
    idle(); ia = 3;
    chk(3, 0, 0, "clr_done"); chk(2, 0, 1, "clr_irdy_after");
    tick();
    for (int a = 0; a < 32; a++) begin
      raddr[0] = 5'(a); raddr[1] = 5'(31 - a);
      chk(0, 0, 0, "clr_rd0"); chk(0, 1, 0, "clr_rd1");
      chk(1, 0, 0, "clr_busy0"); chk(1, 1, 0, "clr_busy1");
      tick();
    end

    idle(); wr(0, 20, 32'h2020); iv = 1; ia = 21;
    tick();
    idle(); creq = 1;
    tick();
    for (int k = 1; k <= 9; k++) begin
      idle(); chk(3, 0, 1, "pre_rst_cbusy");
      tick();
    end
    idle(); rst = 1; raddr[0] = 20; raddr[1] = 21; ia = 21;
    chk(3, 0, 0, "rst_abort"); chk(2, 0, 1, "rst_abort_rdy");
    chk(0, 0, 0, "rst_abort_x20"); chk(1, 1, 0, "rst_abort_b21");
    tick();
    rst = 0; idle();
    chk(3, 0, 0, "post_rst_cbusy"); chk(0, 0, 0, "post_rst_x20");
    tick();

    idle(); wr16(0, 20, 32'hDEAD); wr16(1, 4, 32'h44);
    tick();
    idle(); raddr16[0] = 20; raddr16[1] = 4; iv16 = 1; ia16 = 20;
    chk(4, 0, 0, "oor_rd"); chk(5, 0, 0, "oor_busy"); chk(4, 1, 32'h44, "rv32e_wr");
    chk(6, 0, 1, "oor_rdy");
    tick();
    for (int a = 0; a < 16; a++) begin
      idle(); raddr16[0] = 5'(a); raddr16[1] = 5'(a + 16);
      chk(5, 0, 0, "oor_iss_busy_lo"); chk(5, 1, 0, "oor_iss_busy_hi");
      tick();
    end
    idle(); creq16 = 1;
    tick();
    for (int k = 1; k <= 15; k++) begin
      idle(); chk(7, 0, 1, "rv32e_cbusy");
      tick();
    end
    idle(); raddr16[1] = 4;
    chk(7, 0, 0, "rv32e_clr_len"); chk(4, 1, 0, "rv32e_clr_x4");
    tick();

    tick();
    tick();
    if (bad != 0) $display("FAIL: %0d of %0d checks failed", bad, total);
    else          $display("PASS: all %0d checks passed", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
